mem_fill: RTL and testbench

- Parametrised successor to the ARC4 `init` block: sequentially writes a pattern into a single-port synchronous RAM (the S-array or any scratch memory).
- Supports configurable data width, address width and depth, plus three fill modes: identity, constant and strided ramp.
- Sits between the top-level controller and the memory write port; uses the codebase's en/rdy request handshake so the controller can chain it ahead of ksa/prga.

---
 rtl/mem_fill_pkg.sv | 14 +
 rtl/mem_fill_if.sv | 25 ++
 rtl/mem_fill_gen.sv | 40 ++++
 rtl/mem_fill.sv | 105 ++++++++++
 tb/tb_mem_fill.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/mem_fill_pkg.sv
// mem_fill_pkg: shared types for the mem_fill pattern writer
package mem_fill_pkg;
  localparam int MODE_W = 2;
  typedef enum logic [MODE_W-1:0] {
    MODE_IDENT = 2'd0,
    MODE_CONST = 2'd1,
    MODE_RAMP  = 2'd2
  } mode_t;
  typedef enum logic [1:0] {
    IDLE,
    FILL,
    VERIFY
  } state_t;
endpackage

// File: rtl/mem_fill_if.sv
// mem_fill_if: request handshake plus memory write port; MEM_FILL_VERIFY_EN adds rddata/err
interface mem_fill_if
  import mem_fill_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              en;
  logic              rdy;
  logic [MODE_W-1:0] mode;
  logic [DATA_W-1:0] start;
  logic [DATA_W-1:0] stride;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wrdata;
  logic              wren;
`ifdef MEM_FILL_VERIFY_EN
  logic [DATA_W-1:0] rddata;
  logic              err;
  modport slave  (input en, mode, start, stride, rddata, output rdy, addr, wrdata, wren, err);
  modport master (output en, mode, start, stride, rddata, input rdy, addr, wrdata, wren, err);
`else
  modport slave  (input en, mode, start, stride, output rdy, addr, wrdata, wren);
  modport master (output en, mode, start, stride, input rdy, addr, wrdata, wren);
`endif
endinterface

// File: rtl/mem_fill_gen.sv
// mem_fill_gen: index counter and ramp accumulator producing the fill value for each address
module mem_fill_gen
  import mem_fill_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [MODE_W-1:0] mode_i,
  input  logic [DATA_W-1:0] base_i,
  input  logic [DATA_W-1:0] const_i,
  input  logic [DATA_W-1:0] stride_i,
  output logic [ADDR_W-1:0] idx_o,
  output logic [DATA_W-1:0] val_o,
  output logic              last_o
);
  logic [ADDR_W-1:0] idx_q;
  logic [DATA_W-1:0] acc_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      acc_q <= '0;
    end else if (load_i) begin
      idx_q <= '0;
      acc_q <= base_i;
    end else if (step_i) begin
      idx_q <= idx_q + ADDR_W'(1);
      acc_q <= acc_q + stride_i;
    end
  end
  // last-index compare keeps DEPTH == 2**ADDR_W from needing a wider counter
  assign last_o = idx_q == ADDR_W'(DEPTH - 1);
  assign idx_o  = idx_q;
  assign val_o  = mode_i == MODE_CONST ? const_i :
                  mode_i == MODE_RAMP  ? acc_q   : DATA_W'(idx_q);
endmodule

// File: rtl/mem_fill.sv
// mem_fill: writes identity/constant/ramp pattern into a RAM behind an en/rdy handshake
// MEM_FILL_VERIFY_EN adds a read-back VERIFY pass with sticky err
module mem_fill
  import mem_fill_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input logic       clk,
  input logic       rst_n,
  mem_fill_if.slave bus
);
  state_t            state_q;
  logic              rdy_q, wren_q, last, accept, load;
  logic [MODE_W-1:0] mode_q;
  logic [DATA_W-1:0] start_q, stride_q, val;
  logic [ADDR_W-1:0] idx;
  assign accept = bus.en && state_q == IDLE;
`ifdef MEM_FILL_VERIFY_EN
  logic              err_q, chk_q, tail_q;
  logic [DATA_W-1:0] exp_q;
  // generator rewinds at the end of FILL to replay expected values for VERIFY
  assign load    = accept || (state_q == FILL && last);
  assign bus.err = err_q;
`else
  assign load = accept;
`endif
  assign bus.rdy    = rdy_q;
  assign bus.wren   = wren_q;
  assign bus.addr   = idx;
  assign bus.wrdata = val;
  mem_fill_gen #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) u_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (load),
    .step_i  (state_q != IDLE && !last),
    .mode_i  (mode_q),
    .base_i  (accept ? bus.start : start_q),
    .const_i (start_q),
    .stride_i(stride_q),
    .idx_o   (idx),
    .val_o   (val),
    .last_o  (last)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rdy_q    <= 1'b1;
      wren_q   <= 1'b0;
      mode_q   <= '0;
      start_q  <= '0;
      stride_q <= '0;
`ifdef MEM_FILL_VERIFY_EN
      err_q    <= 1'b0;
      chk_q    <= 1'b0;
      tail_q   <= 1'b0;
      exp_q    <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: if (bus.en) begin
          state_q  <= FILL;
          rdy_q    <= 1'b0;
          wren_q   <= 1'b1;
          mode_q   <= bus.mode;
          start_q  <= bus.start;
          stride_q <= bus.stride;
`ifdef MEM_FILL_VERIFY_EN
          err_q    <= 1'b0;
`endif
        end
        FILL: if (last) begin
          wren_q  <= 1'b0;
`ifdef MEM_FILL_VERIFY_EN
          state_q <= VERIFY;
          chk_q   <= 1'b0;
          tail_q  <= 1'b0;
`else
          state_q <= IDLE;
          rdy_q   <= 1'b1;
`endif
        end
`ifdef MEM_FILL_VERIFY_EN
        // rddata lags addr by one cycle, so compare against the value issued last cycle
        VERIFY: begin
          chk_q  <= !tail_q;
          exp_q  <= val;
          tail_q <= last;
          if (chk_q && bus.rddata != exp_q) err_q <= 1'b1;
          if (tail_q) begin
            state_q <= IDLE;
            rdy_q   <= 1'b1;
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_fill.sv
// tb_mem_fill: table-driven fills on a 256-word and a 1-word instance plus handshake/reset sequences
module tb_mem_fill;
  localparam int DW = 8, AW = 8, DA = 256, DB = 1;
`ifdef MEM_FILL_VERIFY_EN
  localparam int LOWA = 2 * DA + 1, LOWB = 2 * DB + 1;
`else
  localparam int LOWA = DA, LOWB = DB;
`endif
  logic clk = 1'b0, rst_n = 1'b1;
  always #5 clk = ~clk;
  mem_fill_if #(.DATA_W(DW), .ADDR_W(AW)) a ();
  mem_fill_if #(.DATA_W(DW), .ADDR_W(AW)) b ();
  mem_fill #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DA)) u_a (.clk(clk), .rst_n(rst_n), .bus(a));
  mem_fill #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DB)) u_b (.clk(clk), .rst_n(rst_n), .bus(b));
  logic [7:0] mem [DA];
  logic [7:0] mem_b;
  int wa = 0, wb = 0;
  bit corrupt = 1'b0;
  always @(posedge clk) if (a.wren === 1'b1) begin
    mem[a.addr] <= (corrupt && a.addr == 8'h42) ? a.wrdata ^ 8'h01 : a.wrdata;
    wa++;
  end
  always @(posedge clk) if (b.wren === 1'b1) begin
    mem_b <= b.wrdata;
    wb++;
  end
`ifdef MEM_FILL_VERIFY_EN
  always @(posedge clk) begin
    a.rddata <= mem[a.addr];
    b.rddata <= mem_b;
  end
`endif
  int pass = 0, total = 0;
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  function automatic logic [7:0] expv(logic [1:0] m, logic [7:0] s, logic [7:0] st, int i);
    return m == 2'd1 ? s : m == 2'd2 ? 8'(int'(s) + i * int'(st)) : 8'(i);
  endfunction
  // one request on instance a; pulses en and scrambles inputs mid-fill, which must be ignored
  task automatic req_a(input logic [1:0] m, input logic [7:0] s, input logic [7:0] st,
                       output int low, output logic [7:0] fa, output logic [7:0] fd, output logic fw);
    @(negedge clk);
    a.en = 1'b1; a.mode = m; a.start = s; a.stride = st;
    @(negedge clk);
    a.en = 1'b0;
    fa = a.addr; fd = a.wrdata; fw = a.wren;
    low = 0;
    while (!a.rdy && low < 2000) begin
      if (low == 10) begin
        a.en = 1'b1; a.mode = ~m; a.start = ~s; a.stride = ~st;
      end else a.en = 1'b0;
      low++;
      @(negedge clk);
    end
    a.en = 1'b0;
  endtask
  typedef struct {
    logic [1:0] m;
    logic [7:0] s, st, w0, w35, wl;
  } vec_t;
  vec_t v [5];
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int low, low2, hi, n, base, bad;
    logic [7:0] fa, fd;
    logic fw;
    v[0] = '{2'd0, 8'h33, 8'h11, 8'h00, 8'h23, 8'hFF};
    v[1] = '{2'd1, 8'hA5, 8'h3C, 8'hA5, 8'hA5, 8'hA5};
    v[2] = '{2'd2, 8'h10, 8'h07, 8'h10, 8'h05, 8'h09};
    v[3] = '{2'd3, 8'h77, 8'h01, 8'h00, 8'h23, 8'hFF};
    v[4] = '{2'd2, 8'hFF, 8'hFF, 8'hFF, 8'hDC, 8'h00};
    a.en = 1'b0; a.mode = 2'd0; a.start = 8'h00; a.stride = 8'h00;
    b.en = 1'b0; b.mode = 2'd0; b.start = 8'h00; b.stride = 8'h00;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_rdy", a.rdy, 1);
    chk("reset_wren", a.wren, 0);
    chk("reset_addr", a.addr, 0);
    chk("reset_wrdata", a.wrdata, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    // reset at i=100 of a ramp fill
    base = wa;
    @(negedge clk);
    a.en = 1'b1; a.mode = 2'd2; a.start = 8'h00; a.stride = 8'h01;
    @(negedge clk);
    a.en = 1'b0;
    n = 0;
    while (a.addr != 8'd100 && n < 1000) begin
      n++;
      @(negedge clk);
    end
    chk("reach_i100", a.addr, 100);
    rst_n = 1'b0;
    #1;
    chk("midrst_wren", a.wren, 0);
    chk("midrst_rdy", a.rdy, 1);
    chk("midrst_addr", a.addr, 0);
    chk("midrst_writes", wa - base, 100);
    repeat (2) @(negedge clk);
    chk("midrst_no_more_writes", wa - base, 100);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      base = wa;
      req_a(v[k].m, v[k].s, v[k].st, low, fa, fd, fw);
      chk("first_addr", fa, 0);
      chk("first_wren", fw, 1);
      chk("first_data", fd, v[k].w0);
      chk("rdy_low", low, LOWA);
      chk("writes", wa - base, DA);
      chk("word0", mem[0], v[k].w0);
      chk("word35", mem[35], v[k].w35);
      chk("word255", mem[255], v[k].wl);
      bad = 0;
      for (int i = 0; i < DA; i++) if (mem[i] !== expv(v[k].m, v[k].s, v[k].st, i)) bad++;
      chk("all_words_bad", bad, 0);
      chk("idle_wren", a.wren, 0);
      chk("hold_addr", a.addr, 8'hFF);
      chk("hold_wrdata", a.wrdata, v[k].wl);
`ifdef MEM_FILL_VERIFY_EN
      chk("err_clean", a.err, 0);
`endif
    end
    // en held high: back-to-back fills with a single rdy cycle between them
    base = wa;
    @(negedge clk);
    a.en = 1'b1; a.mode = 2'd0;
    @(negedge clk);
    low = 0;
    while (!a.rdy && low < 2000) begin low++; @(negedge clk); end
    hi = 0;
    while (a.rdy && hi < 10) begin hi++; @(negedge clk); end
    low2 = 0;
    while (!a.rdy && low2 < 2000) begin low2++; @(negedge clk); end
    a.en = 1'b0;
    chk("b2b_low1", low, LOWA);
    chk("b2b_gap", hi, 1);
    chk("b2b_low2", low2, LOWA);
    chk("b2b_writes", wa - base, 2 * DA);
    @(negedge clk);
    chk("b2b_stops", a.rdy, 1);
`ifdef MEM_FILL_VERIFY_EN
    corrupt = 1'b1;
    req_a(2'd0, 8'h00, 8'h00, low, fa, fd, fw);
    chk("verify_low", low, LOWA);
    chk("verify_err_set", a.err, 1);
    corrupt = 1'b0;
    req_a(2'd0, 8'h00, 8'h00, low, fa, fd, fw);
    chk("verify_err_clear", a.err, 0);
`endif
    // single-word instance
    @(negedge clk);
    b.en = 1'b1; b.mode = 2'd1; b.start = 8'h5A; b.stride = 8'h00;
    @(negedge clk);
    b.en = 1'b0;
    chk("b_first_wren", b.wren, 1);
    chk("b_first_addr", b.addr, 0);
    chk("b_first_data", b.wrdata, 8'h5A);
    n = 0;
    while (!b.rdy && n < 20) begin n++; @(negedge clk); end
    chk("b_rdy_low", n, LOWB);
    chk("b_writes", wb, 1);
    chk("b_mem", mem_b, 8'h5A);
    chk("b_idle_wren", b.wren, 0);
`ifdef MEM_FILL_VERIFY_EN
    chk("b_err", b.err, 0);
`endif
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
